// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, FSM state type and burst-type helper for ahb_mst_arb.
package ahb_pkg;

  localparam int unsigned LEN_W = 3;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;

  localparam logic [2:0] HSIZE_WORD      = 3'b010;
  localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_BURST,
    ST_LAST,
    ST_ERR1
  } state_t;

  // Attributes of the granted command held for the whole burst
  typedef struct packed {
    logic             write;
    logic [LEN_W-1:0] len;
  } cmd_t;

  // Map beats-1 to the AHB burst encoding
  function automatic logic [2:0] hburst_of(input logic [LEN_W-1:0] len);
    case (len)
      3'd0:    return HBURST_SINGLE;
      3'd3:    return HBURST_INCR4;
      3'd7:    return HBURST_INCR8;
      default: return HBURST_INCR;
    endcase
  endfunction

endpackage

// File: rtl/ahb_rr_arb.sv
// Two-way request picker with last-grant pointer; only picks while en is high.
// Macro AHB_MST_ARB_FIXED_PRIO_EN: requester 0 always wins, pointer removed.
module ahb_rr_arb (
  input  logic       hclk,
  input  logic       hresetn,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] pick_c
);

`ifdef AHB_MST_ARB_FIXED_PRIO_EN
  logic unused_clk_rst;
  assign unused_clk_rst = hclk ^ hresetn;

  // Fixed priority: requester 0 first
  always_comb begin
    pick_c = 2'b00;
    if (en) begin
      if (req[0])      pick_c = 2'b01;
      else if (req[1]) pick_c = 2'b10;
    end
  end
`else
  logic last_q;

  // Round-robin pick: on contention favour the requester not granted last
  always_comb begin
    pick_c = 2'b00;
    if (en) begin
      case (req)
        2'b01:   pick_c = 2'b01;
        2'b10:   pick_c = 2'b10;
        2'b11:   pick_c = last_q ? 2'b01 : 2'b10;
        default: pick_c = 2'b00;
      endcase
    end
  end

  // Last-grant pointer; reset value makes requester 0 win first
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn)          last_q <= 1'b1;
    else if (en && (|req)) last_q <= pick_c[1];
  end
`endif

endmodule

// File: rtl/ahb_mst_arb.sv
// AHB-Lite master sharing one port between two burst requesters.
// Macro AHB_MST_ARB_FIXED_PRIO_EN (in ahb_rr_arb): fixed priority instead of round-robin.
module ahb_mst_arb
  import ahb_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic [1:0]            req,
  input  logic [1:0]            cmd_write,
  input  logic [2*AW-1:0]       cmd_addr,
  input  logic [2*LEN_W-1:0]    cmd_len,
  input  logic [2*DW-1:0]       wdata,
  output logic [1:0]            gnt,
  output logic [1:0]            wnext,
  output logic [DW-1:0]         rdata,
  output logic [1:0]            rvalid,
  output logic [1:0]            done,
  output logic [1:0]            err,
  input  logic                  hready,
  input  logic                  hresp,
  input  logic [DW-1:0]         hrdata,
  output logic [AW-1:0]         haddr,
  output logic [DW-1:0]         hwdata,
  output logic                  hwrite,
  output logic [2:0]            hsize,
  output logic [2:0]            hburst,
  output logic [3:0]            hprot,
  output logic [1:0]            htrans
);

  state_t           state;
  cmd_t             cmd_q;
  logic             sel;
  logic [LEN_W-1:0] beat;
  logic             dphase;

  logic [1:0]       pick_c;
  logic             idx_c;
  cmd_t             new_cmd_c;
  logic [AW-1:0]    new_addr_c;
  logic [DW-1:0]    cur_wdata_c;
  logic             data_err_c;

  assign hsize = HSIZE_WORD;
  assign hprot = HPROT_DATA_PRIV;

  ahb_rr_arb u_arb (
    .hclk    (hclk),
    .hresetn (hresetn),
    .en      (state == ST_IDLE),
    .req     (req),
    .pick_c  (pick_c)
  );

  // Slice selection for the winning requester and the granted requester
  always_comb begin
    idx_c           = pick_c[1];
    new_cmd_c.write = cmd_write[idx_c];
    new_cmd_c.len   = idx_c ? cmd_len[2*LEN_W-1:LEN_W] : cmd_len[LEN_W-1:0];
    new_addr_c      = idx_c ? cmd_addr[2*AW-1:AW] : cmd_addr[AW-1:0];
    cur_wdata_c     = sel ? wdata[2*DW-1:DW] : wdata[DW-1:0];
    data_err_c      = dphase && hresp;
  end

  // Burst FSM with pipelined address/data phases; all bus and requester outputs registered
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state  <= ST_IDLE;
      cmd_q  <= '0;
      sel    <= 1'b0;
      beat   <= '0;
      dphase <= 1'b0;
      gnt    <= '0;
      wnext  <= '0;
      rvalid <= '0;
      done   <= '0;
      err    <= '0;
      rdata  <= '0;
      haddr  <= '0;
      hwdata <= '0;
      hwrite <= 1'b0;
      hburst <= HBURST_SINGLE;
      htrans <= HTRANS_IDLE;
    end else begin
      wnext  <= '0;
      rvalid <= '0;
      done   <= '0;
      err    <= '0;
      if (hready) dphase <= (htrans != HTRANS_IDLE);

      case (state)
        ST_IDLE: begin
          if (|pick_c) begin
            gnt    <= pick_c;
            sel    <= idx_c;
            cmd_q  <= new_cmd_c;
            beat   <= '0;
            haddr  <= new_addr_c;
            hwrite <= new_cmd_c.write;
            hburst <= hburst_of(new_cmd_c.len);
            htrans <= HTRANS_NONSEQ;
            state  <= ST_ADDR;
          end
        end

        ST_ADDR, ST_BURST, ST_LAST: begin
          if (data_err_c) begin
            // First ERROR cycle cancels the pending beats; second one ends the burst
            htrans <= HTRANS_IDLE;
            if (hready) begin
              err    <= gnt;
              gnt    <= '0;
              dphase <= 1'b0;
              state  <= ST_IDLE;
            end else begin
              state  <= ST_ERR1;
            end
          end else if (hready) begin
            if (dphase && !cmd_q.write) begin
              rdata  <= hrdata;
              rvalid <= gnt;
            end
            if (state == ST_LAST) begin
              done  <= gnt;
              gnt   <= '0;
              state <= ST_IDLE;
            end else begin
              // Address phase of the current beat accepted
              if (cmd_q.write) begin
                hwdata <= cur_wdata_c;
                wnext  <= gnt;
              end
              if (beat == cmd_q.len) begin
                htrans <= HTRANS_IDLE;
                state  <= ST_LAST;
              end else begin
                beat   <= beat + LEN_W'(1);
                haddr  <= haddr + AW'(4);
                htrans <= HTRANS_SEQ;
                state  <= ST_BURST;
              end
            end
          end
        end

        ST_ERR1: begin
          if (hready) begin
            err    <= gnt;
            gnt    <= '0;
            dphase <= 1'b0;
            state  <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_mst_arb.sv
// Directed self-checking bench for ahb_mst_arb.
module tb_ahb_mst_arb;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic            hclk = 1'b0;
  logic            hresetn;
  logic [1:0]      req;
  logic [1:0]      cmd_write;
  logic [2*AW-1:0] cmd_addr;
  logic [5:0]      cmd_len;
  logic [2*DW-1:0] wdata;
  logic [1:0]      gnt, wnext, rvalid, done, err;
  logic [DW-1:0]   rdata;
  logic            hready, hresp;
  logic [DW-1:0]   hrdata;
  logic [AW-1:0]   haddr;
  logic [DW-1:0]   hwdata;
  logic            hwrite;
  logic [2:0]      hsize, hburst;
  logic [3:0]      hprot;
  logic [1:0]      htrans;

  int checks = 0;
  int errors = 0;

  always #5 hclk = ~hclk;

  ahb_mst_arb #(.AW(AW), .DW(DW)) dut (
    .hclk(hclk), .hresetn(hresetn), .req(req), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wdata(wdata), .gnt(gnt),
    .wnext(wnext), .rdata(rdata), .rvalid(rvalid), .done(done), .err(err),
    .hready(hready), .hresp(hresp), .hrdata(hrdata), .haddr(haddr),
    .hwdata(hwdata), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .hprot(hprot), .htrans(htrans)
  );

  function automatic logic [31:0] wword(input int k);
    return 32'hD000_0000 + 32'(k);
  endfunction

  task automatic test_reset;
    hresetn = 1'b0; req = '0; cmd_write = '0; cmd_addr = '0; cmd_len = '0; wdata = '0;
    hready = 1'b1; hresp = 1'b0; hrdata = 32'hA5A5_A5A5;
    repeat (2) @(negedge hclk);
    checks++; if (htrans !== 2'b00) begin errors++; $display("FAIL reset_htrans got %h exp 0", htrans); end
    checks++; if (haddr !== 32'h0) begin errors++; $display("FAIL reset_haddr got %h exp 0", haddr); end
    checks++; if (hwdata !== 32'h0) begin errors++; $display("FAIL reset_hwdata got %h exp 0", hwdata); end
    checks++; if (hwrite !== 1'b0) begin errors++; $display("FAIL reset_hwrite got %b exp 0", hwrite); end
    checks++; if (hburst !== 3'b000) begin errors++; $display("FAIL reset_hburst got %b exp 000", hburst); end
    checks++; if (hsize !== 3'b010) begin errors++; $display("FAIL reset_hsize got %b exp 010", hsize); end
    checks++; if (hprot !== 4'b0011) begin errors++; $display("FAIL reset_hprot got %b exp 0011", hprot); end
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b exp 00", gnt); end
    checks++; if (wnext !== 2'b00) begin errors++; $display("FAIL reset_wnext got %b exp 00", wnext); end
    checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL reset_rvalid got %b exp 00", rvalid); end
    checks++; if (done !== 2'b00) begin errors++; $display("FAIL reset_done got %b exp 00", done); end
    checks++; if (err !== 2'b00) begin errors++; $display("FAIL reset_err got %b exp 00", err); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata); end
    hresetn = 1'b1;
    @(negedge hclk);
  endtask

  task automatic test_write_incr8;
    int wptr, wn;
    logic [31:0] ea;
    wptr = 0; wn = 0;
    cmd_write = 2'b01; cmd_addr[31:0] = 32'h100; cmd_len[2:0] = 3'd7; wdata[31:0] = wword(0);
    req = 2'b01;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge hclk);
      if (wnext[0]) begin wn++; wptr++; wdata[31:0] = wword(wptr); end
      if (cyc == 1) begin
        checks++; if (htrans !== 2'b10) begin errors++; $display("FAIL w8_nonseq got %h exp 2", htrans); end
        checks++; if (haddr !== 32'h100) begin errors++; $display("FAIL w8_addr0 got %h exp 100", haddr); end
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL w8_gnt got %b exp 01", gnt); end
        checks++; if (hburst !== 3'b101) begin errors++; $display("FAIL w8_hburst got %b exp 101", hburst); end
        checks++; if (hwrite !== 1'b1) begin errors++; $display("FAIL w8_hwrite got %b exp 1", hwrite); end
      end else if (cyc <= 8) begin
        ea = 32'h100 + 32'(4 * (cyc - 1));
        checks++; if (htrans !== 2'b11) begin errors++; $display("FAIL w8_seq c%0d got %h exp 3", cyc, htrans); end
        checks++; if (haddr !== ea) begin errors++; $display("FAIL w8_addr c%0d got %h exp %h", cyc, haddr, ea); end
        checks++; if (hwdata !== wword(cyc - 2)) begin errors++; $display("FAIL w8_hwdata c%0d got %h exp %h", cyc, hwdata, wword(cyc - 2)); end
      end else if (cyc == 9) begin
        checks++; if (htrans !== 2'b00) begin errors++; $display("FAIL w8_last_idle got %h exp 0", htrans); end
        checks++; if (hwdata !== wword(7)) begin errors++; $display("FAIL w8_hwdata7 got %h exp %h", hwdata, wword(7)); end
        checks++; if (done !== 2'b00) begin errors++; $display("FAIL w8_early_done got %b exp 00", done); end
      end else begin
        checks++; if (done !== 2'b01) begin errors++; $display("FAIL w8_done got %b exp 01", done); end
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL w8_gnt_clr got %b exp 00", gnt); end
        req = 2'b00;
      end
    end
    checks++; if (wn != 8) begin errors++; $display("FAIL w8_wnext_count got %0d exp 8", wn); end
  endtask

  task automatic test_read_single;
    cmd_write = 2'b00; cmd_addr[63:32] = 32'h200; cmd_len[5:3] = 3'd0; hrdata = 32'hA5A5_A5A5;
    req = 2'b10;
    @(negedge hclk);
    checks++; if (htrans !== 2'b10) begin errors++; $display("FAIL rs_nonseq got %h exp 2", htrans); end
    checks++; if (haddr !== 32'h200) begin errors++; $display("FAIL rs_addr got %h exp 200", haddr); end
    checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL rs_gnt got %b exp 10", gnt); end
    checks++; if (hburst !== 3'b000) begin errors++; $display("FAIL rs_hburst got %b exp 000", hburst); end
    checks++; if (hwrite !== 1'b0) begin errors++; $display("FAIL rs_hwrite got %b exp 0", hwrite); end
    @(negedge hclk);
    checks++; if (htrans !== 2'b00) begin errors++; $display("FAIL rs_last_idle got %h exp 0", htrans); end
    checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL rs_early_rvalid got %b exp 00", rvalid); end
    @(negedge hclk);
    checks++; if (rvalid !== 2'b10) begin errors++; $display("FAIL rs_rvalid got %b exp 10", rvalid); end
    checks++; if (rdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL rs_rdata got %h exp a5a5a5a5", rdata); end
    checks++; if (done !== 2'b10) begin errors++; $display("FAIL rs_done got %b exp 10", done); end
    req = 2'b00;
    @(negedge hclk);
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_g [3];
    logic [1:0] last_tr;
    logic [31:0] ea;
    int n, rv;
    bit found;
`ifdef AHB_MST_ARB_FIXED_PRIO_EN
    exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01;
`else
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
`endif
    cmd_write = 2'b00; cmd_addr = {32'h400, 32'h300}; cmd_len = {3'd3, 3'd3};
    last_tr = 2'bxx;
    req = 2'b11;
    for (int b = 0; b < 3; b++) begin
      found = 1'b0; n = 0;
      while (!found && n < 20) begin
        @(negedge hclk); n++;
        if (htrans == 2'b10) found = 1'b1; else last_tr = htrans;
      end
      checks++; if (!found) begin errors++; $display("FAIL rr_nonseq_timeout burst %0d got none exp NONSEQ", b); end
      if (b > 0) begin
        checks++; if (last_tr !== 2'b00) begin errors++; $display("FAIL rr_gap burst %0d got %h exp 0", b, last_tr); end
      end
      ea = (exp_g[b] == 2'b01) ? 32'h300 : 32'h400;
      checks++; if (gnt !== exp_g[b]) begin errors++; $display("FAIL rr_gnt burst %0d got %b exp %b", b, gnt, exp_g[b]); end
      checks++; if (haddr !== ea) begin errors++; $display("FAIL rr_addr burst %0d got %h exp %h", b, haddr, ea); end
      n = 0; rv = 0;
      do begin
        @(negedge hclk); n++;
        if (|rvalid) rv++;
      end while (done == 2'b00 && n < 20);
      checks++; if (done !== exp_g[b]) begin errors++; $display("FAIL rr_done burst %0d got %b exp %b", b, done, exp_g[b]); end
      checks++; if (rv != 4) begin errors++; $display("FAIL rr_rvalid_count burst %0d got %0d exp 4", b, rv); end
      last_tr = htrans;
      if (b == 2) req = 2'b00;
    end
    @(negedge hclk);
  endtask

  task automatic test_wait_states;
    int wptr;
    logic [31:0] ea, ed;
    wptr = 0;
    cmd_write = 2'b01; cmd_addr[31:0] = 32'h500; cmd_len[2:0] = 3'd3; wdata[31:0] = wword(0);
    req = 2'b01;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge hclk);
      if (wnext[0]) begin wptr++; wdata[31:0] = wword(wptr); end
      case (cyc)
        1: begin
          checks++; if (htrans !== 2'b10) begin errors++; $display("FAIL ws_nonseq got %h exp 2", htrans); end
          checks++; if (hburst !== 3'b011) begin errors++; $display("FAIL ws_hburst got %b exp 011", hburst); end
        end
        2, 3, 4, 5, 6: begin
          ea = (cyc == 2) ? 32'h504 : (cyc == 6) ? 32'h50C : 32'h508;
          ed = (cyc == 2) ? wword(0) : (cyc == 6) ? wword(2) : wword(1);
          checks++; if (htrans !== 2'b11) begin errors++; $display("FAIL ws_seq c%0d got %h exp 3", cyc, htrans); end
          checks++; if (haddr !== ea) begin errors++; $display("FAIL ws_addr c%0d got %h exp %h", cyc, haddr, ea); end
          checks++; if (hwdata !== ed) begin errors++; $display("FAIL ws_hwdata c%0d got %h exp %h", cyc, hwdata, ed); end
          if (cyc == 4 || cyc == 5) begin
            checks++; if (wnext !== 2'b00) begin errors++; $display("FAIL ws_wnext_stall c%0d got %b exp 00", cyc, wnext); end
          end
        end
        7: begin
          checks++; if (htrans !== 2'b00) begin errors++; $display("FAIL ws_last_idle got %h exp 0", htrans); end
          checks++; if (hwdata !== wword(3)) begin errors++; $display("FAIL ws_hwdata3 got %h exp %h", hwdata, wword(3)); end
        end
        default: begin
          checks++; if (done !== 2'b01) begin errors++; $display("FAIL ws_done got %b exp 01", done); end
          req = 2'b00;
        end
      endcase
      hready = !(cyc == 3 || cyc == 4);
    end
    @(negedge hclk);
  endtask

  task automatic test_error;
    int rv, dn;
    rv = 0; dn = 0;
    cmd_write = 2'b00; cmd_addr[31:0] = 32'h600; cmd_len[2:0] = 3'd7;
    req = 2'b01;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(negedge hclk);
      if (|rvalid) rv++;
      if (|done) dn++;
      case (cyc)
        1: begin
          checks++; if (hburst !== 3'b101) begin errors++; $display("FAIL er_hburst got %b exp 101", hburst); end
        end
        5: begin
          checks++; if (haddr !== 32'h610) begin errors++; $display("FAIL er_addr got %h exp 610", haddr); end
          hresp = 1'b1; hready = 1'b0;
        end
        6: begin
          checks++; if (htrans !== 2'b00) begin errors++; $display("FAIL er_idle got %h exp 0", htrans); end
          checks++; if (err !== 2'b00) begin errors++; $display("FAIL er_early_err got %b exp 00", err); end
          hready = 1'b1;
        end
        7: begin
          checks++; if (err !== 2'b01) begin errors++; $display("FAIL er_err got %b exp 01", err); end
          checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL er_gnt_clr got %b exp 00", gnt); end
          hresp = 1'b0; req = 2'b00;
        end
        default: ;
      endcase
    end
    checks++; if (rv != 3) begin errors++; $display("FAIL er_rvalid_count got %0d exp 3", rv); end
    checks++; if (dn != 0) begin errors++; $display("FAIL er_done_count got %0d exp 0", dn); end
  endtask

  task automatic test_reset_mid;
    int wptr;
    wptr = 0;
    cmd_write = 2'b10; cmd_addr[63:32] = 32'h700; cmd_len[5:3] = 3'd7; wdata[63:32] = wword(16);
    req = 2'b10;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge hclk);
      if (wnext[1]) begin wptr++; wdata[63:32] = wword(16 + wptr); end
    end
    checks++; if (haddr !== 32'h714) begin errors++; $display("FAIL rm_beat5_addr got %h exp 714", haddr); end
    hresetn = 1'b0;
    #1;
    checks++; if (htrans !== 2'b00) begin errors++; $display("FAIL rm_htrans got %h exp 0", htrans); end
    checks++; if (haddr !== 32'h0) begin errors++; $display("FAIL rm_haddr got %h exp 0", haddr); end
    checks++; if (hwdata !== 32'h0) begin errors++; $display("FAIL rm_hwdata got %h exp 0", hwdata); end
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL rm_gnt got %b exp 00", gnt); end
    checks++; if (hwrite !== 1'b0) begin errors++; $display("FAIL rm_hwrite got %b exp 0", hwrite); end
    checks++; if ((done | err | wnext) !== 2'b00) begin errors++; $display("FAIL rm_pulses got %b exp 00", done | err | wnext); end
    req = 2'b00;
    @(negedge hclk);
    hresetn = 1'b1;
    cmd_write = 2'b00; cmd_addr[31:0] = 32'h800; cmd_len[2:0] = 3'd0;
    req = 2'b01;
    @(negedge hclk);
    checks++; if (htrans !== 2'b10) begin errors++; $display("FAIL rm_restart_nonseq got %h exp 2", htrans); end
    checks++; if (haddr !== 32'h800) begin errors++; $display("FAIL rm_restart_addr got %h exp 800", haddr); end
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL rm_restart_gnt got %b exp 01", gnt); end
    repeat (2) @(negedge hclk);
    checks++; if (done !== 2'b01) begin errors++; $display("FAIL rm_restart_done got %b exp 01", done); end
    req = 2'b00;
    @(negedge hclk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_incr8();
    test_read_single();
    test_round_robin();
    test_wait_states();
    test_error();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_mst_arb.md
Name: ahb_mst_arb

Overview:
- Synthesizable AHB-Lite master controller that shares one AHB-Lite master port between two requesters (e.g. DMA and CPU-side command queue).
- Arbitrates per burst and issues SINGLE/INCR4/INCR8/INCR word bursts with pipelined address and data phases.
- Handles hready wait states and the two-cycle ERROR response, and streams write/read data to/from the granted requester.

Parameters:
AW, 32, address width
DW, 32, data width

Ports:
hclk  in  1  bus clock
hresetn  in  1  asynchronous active-low reset
req  in  2  burst request, one bit per requester; held until done/err
cmd_write  in  2  per-requester direction (1=write)
cmd_addr  in  2*AW  per-requester start address; word aligned; burst must not cross 1KB
cmd_len  in  6  per-requester beats-1 (3 bits each, 0..7)
wdata  in  2*DW  per-requester write data for the current beat
gnt  out  2  one-hot grant, held for the whole burst
wnext  out  2  pulse: current write beat accepted; present the next word next cycle
rdata  out  DW  registered read data
rvalid  out  2  pulse: rdata valid for that requester
done  out  2  pulse: burst completed OKAY
err  out  2  pulse: burst aborted by ERROR
hready  in  1  AHB transfer done
hresp  in  1  AHB response (1=ERROR)
hrdata  in  DW  AHB read data
haddr  out  AW  AHB address
hwdata  out  DW  AHB write data
hwrite  out  1  AHB direction
hsize  out  3  always 3'b010 (word)
hburst  out  3  burst type
hprot  out  4  always 4'b0011
htrans  out  2  IDLE/NONSEQ/SEQ (BUSY never issued)

Behaviour:
- Reset (async, hresetn=0) values:
  - htrans=IDLE, haddr=0, hwdata=0, hwrite=0, hburst=0, hsize=3'b010, hprot=4'b0011.
  - gnt, wnext, rvalid, done, err = 0; rdata=0.
  - RR pointer favours requester 0.
- Reset mid-burst abandons the burst immediately with no done/err.
- FSM states: IDLE, ADDR, BURST, LAST, ERR1.
- IDLE:
  - Arbitrate req.
  - At the next edge: gnt[i]=1; the command is latched; htrans=NONSEQ, haddr=cmd_addr; state ADDR.
  - Request-to-NONSEQ latency is 1 cycle.
- hburst from len:
  - 0 → SINGLE (000)
  - 3 → INCR4 (011)
  - 7 → INCR8 (101)
  - all other lengths → INCR (001)
- Address phase accepted (htrans!=IDLE and hready=1):
  - beat counter increments.
  - Next beat: haddr+4, htrans=SEQ (state BURST).
  - After the last beat's address is accepted: htrans=IDLE, state LAST.
- hready=0 holds all address-phase outputs and hwdata stable.
- Write beats:
  - hwdata is registered from the granted wdata slice when the beat's address phase is accepted.
  - wnext[i] pulses in that same cycle.
- Read beats: when the data phase completes (hready=1, hresp=0): rdata←hrdata and rvalid[i] pulses on the next cycle.
- LAST: when the final data phase completes OKAY → done[i] pulse, gnt cleared, state IDLE.
- Burst spacing: at least one htrans=IDLE cycle between bursts; arbitration only in IDLE.
- Round-robin arbitration:
  - If both req are asserted, grant the requester not granted last.
  - If only one is asserted, grant it.
  - The pointer updates on grant.
- ERROR response:
  - hresp=1 & hready=0 during a data phase → next cycle htrans=IDLE, cancel pending beats, state ERR1.
  - hresp=1 & hready=1 → err[i] pulse, gnt cleared, state IDLE.
  - No rvalid or wnext for the errored beat.
- A single-beat burst goes ADDR→LAST directly.
- Beat counter is 3 bits; no wrap beyond len.

Optional Feature:
AHB_MST_ARB_FIXED_PRIO_EN
- Defined: requester 0 always wins when both request; the RR pointer is removed.
- Undefined: round-robin as above.

Decomposition:
- Package ahb_pkg:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ
  - HBURST_SINGLE/INCR/INCR4/INCR8
  - HSIZE_WORD, HPROT_DATA_PRIV
  - FSM state enum
- Sub-module ahb_rr_arb: two-way picker with last-grant pointer and grant-enable input; it also hosts the fixed-priority macro.

Test Plan:
- req=01, write, addr 0x100, len 7, no waits → NONSEQ@0x100 then SEQ 0x104..0x11C; hburst=101; wnext 8 pulses; done[0] 1 cycle after last data phase.
- req=10, read, addr 0x200, len 0, hrdata=0xA5A5A5A5 → hburst=000; rvalid[1] with rdata=0xA5A5A5A5; done[1].
- Both req held, len 3 each → grants alternate 01,10,01; IDLE cycle between bursts; with FIXED_PRIO_EN defined, 01 every time.
- INCR4 write with hready=0 for 2 cycles on beat 2 → haddr/hwdata/htrans stable during the wait; beat sequence unchanged.
- INCR8 read, ERROR on beat 3 (hresp=1/hready=0 then hresp=1/hready=1) → htrans=IDLE in cycle 2; err[0] pulse; 3 rvalid total; no done.
- hresetn low during beat 5 → all outputs at reset values immediately; next req restarts cleanly from NONSEQ.
